vector_req_gen: RTL
===================

# vector_req_gen

Command-driven request sequencer sitting directly upstream of the banked vector RAM. It accepts a command (base address, element count, direction) and emits one PARALLELISM-wide request beat per cycle of consecutive element addresses, masking tail lanes. Write beats carry data from an input stream. The block tracks outstanding read responses so it can report completion and bound the number of reads in flight.

## Interface
- VECTOR_LENGTH, 32: elements addressable; sets ADDR_WIDTH.
- DATA_WIDTH, 32: element width.
- PARALLELISM, 4: lanes per beat; power of 2.
- MAX_OUTSTANDING, 4: maximum unanswered read beats.
- ADDR_WIDTH (localparam): $clog2(VECTOR_LENGTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_base  in  ADDR_WIDTH  first element address.
- cmd_len  in  ADDR_WIDTH+1  element count (0..VECTOR_LENGTH).
- cmd_write  in  1  1 = write command, 0 = read command.
- wr_data  in  DATA_WIDTH x PARALLELISM  write beat payload.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat consumed.
- addr  out  ADDR_WIDTH x PARALLELISM  request lane addresses.
- wdata  out  DATA_WIDTH x PARALLELISM  request write data.
- write  out  1  request direction.
- lane_en  out  PARALLELISM  per-lane enable; 0 on tail lanes.
- valid  out  1  request beat valid.
- ready  in  1  RAM accepts beat.
- rvalid  in  1  RAM response valid (monitored only).
- rready  in  1  response consumer ready (monitored only).
- done  out  1  one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, ISSUE, DRAIN. cmd_ready = (state == IDLE).
- IDLE: on cmd_valid & cmd_ready, latch base, len, and write. If len == 0, pulse done the next cycle and stay in IDLE. Otherwise go to ISSUE.
- ISSUE: beat k, lane i: addr = base + (k*PARALLELISM + i)*STRIDE mod 2^ADDR_WIDTH (wraps). lane_en[i] = (k*PARALLELISM + i < len).
- Beat count = ceil(len / PARALLELISM).
- Disabled lanes drive addr 0 and wdata 0.
- Request outputs are held in a single registered output stage. A new beat loads when the stage is empty or when valid & ready occurs in the same cycle.
- Reads: a beat loads only if the post-cycle outstanding count is below MAX_OUTSTANDING. A same-cycle response decrement counts.
- Writes: a beat loads only with wr_valid. wr_ready = (state == ISSUE) & write & (stage empty or draining) & beats remaining.
- Outstanding counter (width $clog2(MAX_OUTSTANDING+1)):
  - +1 on a read beat handshake (valid & ready & !write).
  - -1 on rvalid & rready.
  - Both in the same cycle leave it unchanged.
  - Writes produce no responses.
- ISSUE -> DRAIN once the last beat handshakes with the RAM.
- DRAIN -> IDLE when outstanding == 0 and the output stage is empty. done pulses in the cycle the FSM enters IDLE.
- Reset: state IDLE, counters and stage cleared. Asserting rst_n low mid-command abandons it, with no done pulse.

## Timing
- Reset values: cmd_ready 1, wr_ready 0, valid 0, write 0, lane_en 0, addr 0, wdata 0, done 0.
- Read command accepted at cycle 0 -> first valid at cycle 1. With ready held high, one beat per cycle.
- Write beat accepted (wr_valid & wr_ready) at cycle n -> presented on valid at cycle n+1.
- While valid & !ready: addr, wdata, write, and lane_en are held stable, and valid does not drop.
- Write command: done pulses the cycle after the last beat handshake.
- Read command: done pulses the cycle after the final response handshake (rvalid & rready). If the last response coincides with the last beat handshake, done pulses the following cycle.
- The next command can be accepted in the cycle done is high.

## Configuration
- VECTOR_REQ_GEN_STRIDE_EN:
  - Defined: adds input port cmd_stride (ADDR_WIDTH), latched with the command; STRIDE = cmd_stride. A stride of 0 replicates base on all enabled lanes.
  - Undefined: the port is absent and STRIDE = 1 (contiguous).

## Test plan
- Read, base 0, len 8, P=4, ready=1: beats addr {0,1,2,3} and {4,5,6,7}, lane_en 4'b1111, valid at cycles 1-2. Return 2 responses; done pulses 1 cycle after the 2nd.
- Read, base 30, len 6, VECTOR_LENGTH=32: beat 1 addr {30,31,0,1}; beat 2 addr {2,3,0,0} with lane_en 4'b0011.
- Read, len 24, MAX_OUTSTANDING=4, rvalid held 0: exactly 4 beats issue, then valid stays 0. Each rvalid & rready releases exactly one more beat.
- Write, len 8, wr_valid toggling every other cycle, ready low for 3 cycles on beat 1: beat contents match wr_data in order, outputs stable while stalled, no beat is lost or duplicated, and done pulses after beat 2.
- len 0: cmd accepted, done pulses next cycle, valid never asserts. Separately, rst_n pulled low mid-ISSUE: valid drops to 0 immediately, cmd_ready becomes 1, no done pulse.
- With VECTOR_REQ_GEN_STRIDE_EN, stride 2, base 1, len 4: addr {1,3,5,7}.

Source files
------------

// File: rtl/vector_req_gen.sv
// vector_req_gen: command-driven request sequencer for the banked vector RAM.
// Turns (base, len, direction) commands into PARALLELISM-wide request beats,
// masks tail lanes, streams write data and bounds the number of reads in flight.
// Optional feature macro: VECTOR_REQ_GEN_STRIDE_EN (adds cmd_stride; otherwise
// the element stride is fixed at 1).
module vector_req_gen #(
  parameter  int unsigned VECTOR_LENGTH   = 32,
  parameter  int unsigned DATA_WIDTH      = 32,
  parameter  int unsigned PARALLELISM     = 4,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned ADDR_WIDTH      = $clog2(VECTOR_LENGTH)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                  cmd_base,
  input  logic [ADDR_WIDTH:0]                    cmd_len,
  input  logic                                   cmd_write,
`ifdef VECTOR_REQ_GEN_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]                  cmd_stride,
`endif
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  output logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata,
  output logic                                   write,
  output logic [PARALLELISM-1:0]                 lane_en,
  output logic                                   valid,
  input  logic                                   ready,
  input  logic                                   rvalid,
  input  logic                                   rready,
  output logic                                   done
);

  localparam int unsigned LANE_SHIFT = $clog2(PARALLELISM);
  localparam int unsigned CNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BEAT_WIDTH = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                   state;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [ADDR_WIDTH:0]      len_q;
  logic                     write_q;
  logic [BEAT_WIDTH-1:0]    beat_cnt;
  logic [CNT_WIDTH-1:0]     outstanding;
`ifdef VECTOR_REQ_GEN_STRIDE_EN
  logic [ADDR_WIDTH-1:0]    stride_q;
`endif

  logic [ADDR_WIDTH-1:0]    sel_base;
  logic [ADDR_WIDTH-1:0]    sel_stride;
  logic [ADDR_WIDTH:0]      sel_len;
  logic                     sel_write;
  logic [BEAT_WIDTH-1:0]    sel_beat;
  logic [BEAT_WIDTH-1:0]    num_beats;
  logic [BEAT_WIDTH-1:0]    elem;
  logic                     beats_left;
  logic                     hs;
  logic                     rd_hs;
  logic                     rsp;
  logic                     stage_free;
  logic                     cmd_fire;
  logic                     load_first;
  logic                     load_issue;
  logic                     load;
  logic [CNT_WIDTH-1:0]     out_next;
  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] nxt_addr;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] nxt_wdata;
  logic [PARALLELISM-1:0]                 nxt_en;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = beats_left & write_q & stage_free;

  // Beat source: the first read beat is built straight from the command so it
  // appears the cycle after acceptance; later beats use the latched command.
  always_comb begin
    sel_base   = base_q;
    sel_len    = len_q;
    sel_write  = write_q;
    sel_beat   = beat_cnt;
`ifdef VECTOR_REQ_GEN_STRIDE_EN
    sel_stride = stride_q;
`else
    sel_stride = ADDR_WIDTH'(1);
`endif
    if (state == IDLE) begin
      sel_base   = cmd_base;
      sel_len    = cmd_len;
      sel_write  = cmd_write;
      sel_beat   = '0;
`ifdef VECTOR_REQ_GEN_STRIDE_EN
      sel_stride = cmd_stride;
`endif
    end
  end

  // Handshakes, outstanding-read bookkeeping and load decision.
  always_comb begin
    hs         = valid & ready;
    rd_hs      = hs & ~write;
    rsp        = rvalid & rready & (outstanding != '0);
    out_next   = outstanding + CNT_WIDTH'(rd_hs) - CNT_WIDTH'(rsp);
    stage_free = ~valid | ready;
    num_beats  = (BEAT_WIDTH'(len_q) + BEAT_WIDTH'(PARALLELISM - 1)) >> LANE_SHIFT;
    beats_left = (state == ISSUE) && (beat_cnt < num_beats);
    cmd_fire   = cmd_valid & cmd_ready;
    load_first = cmd_fire & ~cmd_write & (cmd_len != '0);
    load_issue = beats_left & stage_free &
                 (write_q ? wr_valid : (out_next < CNT_WIDTH'(MAX_OUTSTANDING)));
    load       = load_first | load_issue;
  end

  // Per-lane address, enable and data for the beat about to be loaded.
  always_comb begin
    nxt_addr  = '0;
    nxt_wdata = '0;
    nxt_en    = '0;
    elem      = '0;
    for (int i = 0; i < int'(PARALLELISM); i++) begin
      elem = (sel_beat << LANE_SHIFT) + BEAT_WIDTH'(i);
      if (elem < BEAT_WIDTH'(sel_len)) begin
        nxt_en[i]   = 1'b1;
        nxt_addr[i] = sel_base + ADDR_WIDTH'(elem) * sel_stride;
        if (sel_write) nxt_wdata[i] = wr_data[i];
      end
    end
  end

  // Sequencer FSM, outstanding counter and registered request stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      write_q     <= 1'b0;
      beat_cnt    <= '0;
      outstanding <= '0;
`ifdef VECTOR_REQ_GEN_STRIDE_EN
      stride_q    <= '0;
`endif
      valid       <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      write       <= 1'b0;
      lane_en     <= '0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= out_next;
      if (load) begin
        valid   <= 1'b1;
        addr    <= nxt_addr;
        wdata   <= nxt_wdata;
        lane_en <= nxt_en;
        write   <= sel_write;
      end else if (hs) begin
        valid   <= 1'b0;
        addr    <= '0;
        wdata   <= '0;
        lane_en <= '0;
        write   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            base_q   <= cmd_base;
            len_q    <= cmd_len;
            write_q  <= cmd_write;
`ifdef VECTOR_REQ_GEN_STRIDE_EN
            stride_q <= cmd_stride;
`endif
            beat_cnt <= BEAT_WIDTH'(load_first);
            if (cmd_len == '0) done  <= 1'b1;
            else               state <= ISSUE;
          end
        end
        ISSUE: begin
          if (load_issue) beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
          if (!beats_left && hs) begin
            if (out_next == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((out_next == '0) && !valid) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
